// File: rtl/gate_codes_pkg.sv
// Shared constants for the two-input gate identification blocks.
//   - CODE_*   : 4-bit gate classification codes (CODE_UNKNOWN for unmatched tables)
//   - St*      : state encodings for the identifier FSM
package gate_codes_pkg;

  localparam logic [3:0] CODE_CONST0  = 4'd0;
  localparam logic [3:0] CODE_AND     = 4'd1;
  localparam logic [3:0] CODE_OR      = 4'd2;
  localparam logic [3:0] CODE_NAND    = 4'd3;
  localparam logic [3:0] CODE_NOR     = 4'd4;
  localparam logic [3:0] CODE_XOR     = 4'd5;
  localparam logic [3:0] CODE_XNOR    = 4'd6;
  localparam logic [3:0] CODE_BUF_A   = 4'd7;
  localparam logic [3:0] CODE_BUF_B   = 4'd8;
  localparam logic [3:0] CODE_NOT_A   = 4'd9;
  localparam logic [3:0] CODE_NOT_B   = 4'd10;
  localparam logic [3:0] CODE_CONST1  = 4'd11;
  localparam logic [3:0] CODE_UNKNOWN = 4'hF;

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StDrive    = 2'd1;
  localparam logic [1:0] StClassify = 2'd2;

endpackage

// File: rtl/gate_tt_classifier.sv
// Combinational classifier: maps a 2-input truth table to a gate code.
//   tt   : truth table, bit index {a,b} (a is MSB)
//   code : matching gate code, CODE_UNKNOWN when no gate matches
module gate_tt_classifier
  import gate_codes_pkg::*;
(
  input  logic [3:0] tt,
  output logic [3:0] code
);

  always_comb begin
    code = CODE_UNKNOWN;
    case (tt)
      4'b0000: code = CODE_CONST0;
      4'b1000: code = CODE_AND;
      4'b1110: code = CODE_OR;
      4'b0111: code = CODE_NAND;
      4'b0001: code = CODE_NOR;
      4'b0110: code = CODE_XOR;
      4'b1001: code = CODE_XNOR;
      4'b1100: code = CODE_BUF_A;
      4'b1010: code = CODE_BUF_B;
      4'b0011: code = CODE_NOT_A;
      4'b0101: code = CODE_NOT_B;
      4'b1111: code = CODE_CONST1;
      default: code = CODE_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/gate_function_identifier.sv
// Drives a 2-input combinational device with a,b = 00,01,10,11, samples its output
// once per vector and classifies the captured truth table.
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin identification (accepted only when idle)
//   dut_out           : output of the device under test
//   probe_a, probe_b  : registered drive to the device inputs
//   busy              : sweep in progress
//   done              : one-cycle pulse, truth_table/gate_code valid
//   truth_table       : captured table, bit index {a,b}
//   gate_code         : classification of truth_table
module gate_function_identifier
  import gate_codes_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       probe_a,
  output logic       probe_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  output logic [3:0] gate_code
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);

  logic [1:0]      state_q, state_d;
  logic [1:0]      vec_q, vec_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      probe_q, probe_d;
  logic [3:0]      shadow_q, shadow_d;
  logic [3:0]      tt_q, tt_d;
  logic [3:0]      code_q, code_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [3:0]      classified;

  gate_tt_classifier u_classifier (
    .tt   (shadow_q),
    .code (classified)
  );

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    probe_d  = probe_q;
    shadow_d = shadow_q;
    tt_d     = tt_q;
    code_d   = code_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        probe_d = 2'b00;
        if (start) begin
          state_d = StDrive;
          vec_d   = 2'd0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StDrive: begin
        if (cnt_q == CntLast) begin
          // Last edge of this vector: capture and move the probes on the same edge.
          shadow_d[vec_q] = dut_out;
          cnt_d           = '0;
          if (vec_q == 2'd3) begin
            state_d = StClassify;
            busy_d  = 1'b0;
            probe_d = 2'b00;
          end else begin
            vec_d   = vec_q + 2'd1;
            probe_d = vec_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StClassify: begin
        tt_d    = shadow_q;
        code_d  = classified;
        done_d  = 1'b1;
        probe_d = 2'b00;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        probe_d = 2'b00;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      vec_q    <= 2'd0;
      cnt_q    <= '0;
      probe_q  <= 2'b00;
      shadow_q <= 4'b0000;
      tt_q     <= 4'b0000;
      code_q   <= CODE_UNKNOWN;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      probe_q  <= probe_d;
      shadow_q <= shadow_d;
      tt_q     <= tt_d;
      code_q   <= code_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign probe_a     = probe_q[1];
  assign probe_b     = probe_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign truth_table = tt_q;
  assign gate_code   = code_q;

endmodule

// File: tb/tb_gate_function_identifier.sv
// Bench for gate_function_identifier: one instance with SETTLE_CYCLES=2 and one with 1.
// The device under test is modelled as a 4-bit truth table, optionally behind a register.
module tb_gate_function_identifier;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1;
  logic out0, out1;
  logic pa0, pb0, busy0, done0;
  logic pa1, pb1, busy1, done1;
  logic [3:0] tt0, code0, tt1, code1;

  logic [3:0] dut_tt;
  bit         reg_mode;
  logic       comb0, comb1, regq0, regq1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign comb0 = dut_tt[{pa0, pb0}];
  assign comb1 = dut_tt[{pa1, pb1}];
  always @(posedge clk) begin
    regq0 <= comb0;
    regq1 <= comb1;
  end
  assign out0 = reg_mode ? regq0 : comb0;
  assign out1 = reg_mode ? regq1 : comb1;

  gate_function_identifier #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .dut_out(out0), .probe_a(pa0), .probe_b(pb0),
    .busy(busy0), .done(done0), .truth_table(tt0), .gate_code(code0)
  );

  gate_function_identifier #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .dut_out(out1), .probe_a(pa1), .probe_b(pb1),
    .busy(busy1), .done(done1), .truth_table(tt1), .gate_code(code1)
  );

  // Reference: evaluate each named gate with plain boolean operators and look for a match.
  function automatic logic gate_eval(input int c, input logic a, input logic b);
    case (c)
      0:       return 1'b0;
      1:       return a & b;
      2:       return a | b;
      3:       return ~(a & b);
      4:       return ~(a | b);
      5:       return a ^ b;
      6:       return ~(a ^ b);
      7:       return a;
      8:       return b;
      9:       return ~a;
      10:      return ~b;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] ref_code(input logic [3:0] tt);
    for (int c = 0; c < 12; c++) begin
      logic [3:0] t;
      for (int i = 0; i < 4; i++) begin
        logic [1:0] idx;
        idx = i[1:0];
        t[i] = gate_eval(c, idx[1], idx[0]);
      end
      if (t == tt) return c[3:0];
    end
    return 4'hF;
  endfunction

  // A one-cycle-late device sampled with a one-cycle settle sees the previous vector's value.
  function automatic logic [3:0] late_table(input logic [3:0] tt);
    return {tt[2], tt[1], tt[0], tt[0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic sample(input int w, output logic [1:0] p, output logic b, output logic d,
                        output logic [3:0] t, output logic [3:0] c);
    if (w == 0) begin
      p = {pa0, pb0}; b = busy0; d = done0; t = tt0; c = code0;
    end else begin
      p = {pa1, pb1}; b = busy1; d = done1; t = tt1; c = code1;
    end
  endtask

  // One identification on instance w; returns result, done latency after the start edge,
  // cycles busy was seen high, and whether the probe sequence matched.
  task automatic run_id(input int w, input logic [3:0] tt, input bit regm,
                        output logic [3:0] gtt, output logic [3:0] gcode,
                        output int lat, output int busy_n, output bit probe_ok);
    int s;
    logic [1:0] p;
    logic b, d;
    s = (w == 0) ? 2 : 1;
    dut_tt = tt;
    reg_mode = regm;
    @(posedge clk); #1;
    if (w == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    lat = -1; busy_n = 0; probe_ok = 1'b1;
    for (int j = 0; j <= 40; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      sample(w, p, b, d, gtt, gcode);
      if (d === 1'b1) begin
        lat = j;
        break;
      end
      if (b === 1'b1) busy_n++;
      if (p !== ((j < 4 * s) ? 2'(j / s) : 2'd0)) probe_ok = 1'b0;
    end
  endtask

  typedef struct {
    logic [3:0] tt;
    logic [3:0] code;
  } vec_t;

  initial begin
    vec_t vecs[12];
    logic [3:0] gtt, gcode;
    int lat, busy_n, n_done;
    bit probe_ok;
    logic [1:0] p;
    logic b, d;
    logic [3:0] t, c;

    vecs[0]  = '{4'b0110, 4'd5};
    vecs[1]  = '{4'b1001, 4'd6};
    vecs[2]  = '{4'b0111, 4'd3};
    vecs[3]  = '{4'b0001, 4'd4};
    vecs[4]  = '{4'b1110, 4'd2};
    vecs[5]  = '{4'b0101, 4'd10};
    vecs[6]  = '{4'b0100, 4'hF};
    vecs[7]  = '{4'b1111, 4'd11};
    vecs[8]  = '{4'b0000, 4'd0};
    vecs[9]  = '{4'b1010, 4'd8};
    vecs[10] = '{4'b0011, 4'd9};
    vecs[11] = '{4'b1100, 4'd7};

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; dut_tt = 4'b0000; reg_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_probes", {pa0, pb0, pa1, pb1}, 4'b0000);
    chk("reset_busy_done", {busy0, done0, busy1, done1}, 4'b0000);
    chk("reset_tt", {tt0, tt1}, 8'h00);
    chk("reset_code0", code0, 4'hF);
    chk("reset_code1", code1, 4'hF);
    rst = 1'b0;

    // AND on the default-settle instance.
    run_id(0, 4'b1000, 1'b0, gtt, gcode, lat, busy_n, probe_ok);
    chk("and_latency", lat, 9);
    chk("and_busy_cycles", busy_n, 8);
    chk("and_probe_seq", probe_ok, 1);
    chk("and_tt", gtt, 4'b1000);
    chk("and_code", gcode, 4'd1);

    foreach (vecs[i]) begin
      run_id(0, vecs[i].tt, 1'b0, gtt, gcode, lat, busy_n, probe_ok);
      chk($sformatf("table_tt_%0d", i), gtt, vecs[i].tt);
      chk($sformatf("table_code_%0d", i), gcode, vecs[i].code);
      chk($sformatf("table_latency_%0d", i), lat, 9);
    end

    // Re-pulsing start during the sweep and in the classify cycle must not restart.
    run_id(0, 4'b1000, 1'b0, gtt, gcode, lat, busy_n, probe_ok);
    dut_tt = 4'b0110;
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    n_done = 0;
    for (int j = 1; j <= 30; j++) begin
      @(posedge clk); #1;
      start0 = (j == 2 || j == 8);
      if (j == 5) chk("held_tt_during_run", tt0, 4'b1000);
      if (j == 5) chk("held_code_during_run", code0, 4'd1);
      if (done0 === 1'b1) begin
        n_done++;
        chk("restart_done_cycle", j, 9);
      end
    end
    chk("restart_done_count", n_done, 1);
    chk("restart_busy_end", busy0, 1'b0);
    chk("restart_tt", tt0, 4'b0110);
    chk("restart_code", code0, 4'd5);
    run_id(0, 4'b0001, 1'b0, gtt, gcode, lat, busy_n, probe_ok);
    chk("after_restart_code", gcode, 4'd4);
    chk("after_restart_latency", lat, 9);

    // Reset while vector 2 is being driven.
    dut_tt = 4'b1110;
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midreset_vec2", {pa0, pb0}, 2'b10);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    sample(0, p, b, d, t, c);
    chk("midreset_probes", p, 2'b00);
    chk("midreset_busy_done", {b, d}, 2'b00);
    chk("midreset_tt", t, 4'b0000);
    chk("midreset_code", c, 4'hF);
    rst = 1'b0;
    n_done = 0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      if (done0 === 1'b1) n_done++;
    end
    chk("midreset_no_done", n_done, 0);
    run_id(0, 4'b1110, 1'b0, gtt, gcode, lat, busy_n, probe_ok);
    chk("midreset_fresh_tt", gtt, 4'b1110);
    chk("midreset_fresh_code", gcode, 4'd2);

    // One-cycle settle, combinational and registered device.
    run_id(1, 4'b1100, 1'b0, gtt, gcode, lat, busy_n, probe_ok);
    chk("s1_latency", lat, 5);
    chk("s1_busy_cycles", busy_n, 4);
    chk("s1_probe_seq", probe_ok, 1);
    chk("s1_tt", gtt, 4'b1100);
    chk("s1_code", gcode, 4'd7);
    run_id(1, 4'b1100, 1'b1, gtt, gcode, lat, busy_n, probe_ok);
    chk("s1_regdut_tt", gtt, late_table(4'b1100));
    chk("s1_regdut_code", gcode, ref_code(late_table(4'b1100)));
    run_id(0, 4'b1100, 1'b1, gtt, gcode, lat, busy_n, probe_ok);
    chk("s2_regdut_tt", gtt, 4'b1100);
    chk("s2_regdut_code", gcode, 4'd7);

    // Random tables against the reference model.
    for (int k = 0; k < 24; k++) begin
      int w;
      bit regm;
      logic [3:0] rt, exp_tt;
      w = int'($urandom_range(0, 1));
      regm = 1'($urandom_range(0, 1));
      rt = 4'($urandom_range(0, 15));
      exp_tt = (w == 1 && regm) ? late_table(rt) : rt;
      run_id(w, rt, regm, gtt, gcode, lat, busy_n, probe_ok);
      chk($sformatf("rand_tt_%0d", k), gtt, exp_tt);
      chk($sformatf("rand_code_%0d", k), gcode, ref_code(exp_tt));
      chk($sformatf("rand_latency_%0d", k), lat, (w == 0) ? 9 : 5);
      chk($sformatf("rand_probe_seq_%0d", k), probe_ok, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
